// File: rtl/dcache_mem_ctrl.sv
// Memory-side responder for the data cache's writeback, write-miss and read-miss streams.
// Requests go through an in-order FIFO to one tagged memory port; load returns become fills.
module dcache_mem_ctrl #(
   parameter int LSQSZ  = 16,
   parameter int QDEPTH = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wb_en,
   input  logic [15:0]       wb_addr,
   input  logic [63:0]       wb_data,
   input  logic [1:0]        wb_size,
   input  logic              wr_en,
   input  logic [15:0]       wr_addr,
   input  logic [63:0]       wr_data,
   input  logic [1:0]        wr_size,
   input  logic              rd_en,
   input  logic [15:0]       rd_addr,
   input  logic [1:0]        rd_size,
   input  logic [LSQSZ-1:0]  rd_gnt,
   output logic              req_stall,
   output logic              overflow_err,
   output logic [1:0]        proc2mem_command,
   output logic [15:0]       proc2mem_addr,
   output logic [63:0]       proc2mem_data,
   output logic [1:0]        proc2mem_size,
   input  logic [3:0]        mem2proc_response,
   input  logic [63:0]       mem2proc_data,
   input  logic [3:0]        mem2proc_tag,
   output logic              mem_wr_en,
   output logic [4:0]        mem_wr_idx,
   output logic [7:0]        mem_wr_tag,
   output logic [63:0]       mem_wr_data,
   output logic [LSQSZ-1:0]  fill_gnt
);

   localparam int PW = $clog2(QDEPTH);
   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_LOAD  = 2'd1;
   localparam logic [1:0] CMD_STORE = 2'd2;

   typedef logic [PW:0]   ptr_t;
   typedef logic [PW+1:0] cnt_t;
   localparam cnt_t DEPTH = cnt_t'(QDEPTH);

   logic [1:0]       r_q_cmd  [QDEPTH];
   logic [15:0]      r_q_addr [QDEPTH];
   logic [63:0]      r_q_data [QDEPTH];
   logic [1:0]       r_q_size [QDEPTH];
   logic [LSQSZ-1:0] r_q_gnt  [QDEPTH];

   logic [15:0]      r_tv;
   logic [12:0]      r_t_addr [16];
   logic [LSQSZ-1:0] r_t_gnt  [16];

   ptr_t             r_wr_ptr, r_rd_ptr;
   logic             r_stall, r_ovf;
   logic             r_mem_wr_en;
   logic [4:0]       r_mem_wr_idx;
   logic [7:0]       r_mem_wr_tag;
   logic [63:0]      r_mem_wr_data;
   logic [LSQSZ-1:0] r_fill_gnt;

   logic [PW-1:0]    w_rd_idx;
   ptr_t             w_used, w_pos1, w_pos2, w_wr_ptr_nxt;
   logic             w_empty, w_pop, w_acc_load, w_ret_hit;
   logic             w_wb_acc, w_wr_acc, w_rd_acc, w_drop, w_stall_nxt;
   cnt_t             w_slots;

   assign w_rd_idx   = r_rd_ptr[PW-1:0];
   assign w_used     = r_wr_ptr - r_rd_ptr;
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_pop      = !w_empty && (mem2proc_response != 4'd0);
   assign w_acc_load = w_pop && (r_q_cmd[w_rd_idx] == CMD_LOAD);
   assign w_ret_hit  = (mem2proc_tag != 4'd0) && r_tv[mem2proc_tag];

   // Slots are granted in priority wb, wr, rd; the pop this cycle frees one slot.
   always_comb begin
      w_slots  = DEPTH - {1'b0, w_used} + cnt_t'(w_pop);
      w_wb_acc = wb_en && (w_slots != '0);
      if (w_wb_acc) w_slots = w_slots - cnt_t'(1);
      w_wr_acc = wr_en && (w_slots != '0);
      if (w_wr_acc) w_slots = w_slots - cnt_t'(1);
      w_rd_acc = rd_en && (w_slots != '0);
      if (w_rd_acc) w_slots = w_slots - cnt_t'(1);
      w_stall_nxt  = (w_slots < cnt_t'(3));
      w_drop       = (wb_en && !w_wb_acc) || (wr_en && !w_wr_acc) || (rd_en && !w_rd_acc);
      w_pos1       = r_wr_ptr + ptr_t'(w_wb_acc);
      w_pos2       = w_pos1 + ptr_t'(w_wr_acc);
      w_wr_ptr_nxt = w_pos2 + ptr_t'(w_rd_acc);
   end

   assign proc2mem_command = w_empty ? CMD_NONE : r_q_cmd[w_rd_idx];
   assign proc2mem_addr    = w_empty ? 16'd0    : r_q_addr[w_rd_idx];
   assign proc2mem_data    = w_empty ? 64'd0    : r_q_data[w_rd_idx];
   assign proc2mem_size    = w_empty ? 2'd0     : r_q_size[w_rd_idx];

   always_ff @(posedge clock) begin
      if (w_wb_acc) begin
         r_q_cmd[r_wr_ptr[PW-1:0]]  <= CMD_STORE;
         r_q_addr[r_wr_ptr[PW-1:0]] <= wb_addr;
         r_q_data[r_wr_ptr[PW-1:0]] <= wb_data;
         r_q_size[r_wr_ptr[PW-1:0]] <= wb_size;
         r_q_gnt[r_wr_ptr[PW-1:0]]  <= '0;
      end
      if (w_wr_acc) begin
         r_q_cmd[w_pos1[PW-1:0]]  <= CMD_STORE;
         r_q_addr[w_pos1[PW-1:0]] <= wr_addr;
         r_q_data[w_pos1[PW-1:0]] <= wr_data;
         r_q_size[w_pos1[PW-1:0]] <= wr_size;
         r_q_gnt[w_pos1[PW-1:0]]  <= '0;
      end
      if (w_rd_acc) begin
         r_q_cmd[w_pos2[PW-1:0]]  <= CMD_LOAD;
         r_q_addr[w_pos2[PW-1:0]] <= rd_addr;
         r_q_data[w_pos2[PW-1:0]] <= 64'd0;
         r_q_size[w_pos2[PW-1:0]] <= rd_size;
         r_q_gnt[w_pos2[PW-1:0]]  <= rd_gnt;
      end
      if (w_acc_load) begin
         r_t_addr[mem2proc_response] <= r_q_addr[w_rd_idx][15:3];
         r_t_gnt[mem2proc_response]  <= r_q_gnt[w_rd_idx];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_tv          <= '0;
         r_stall       <= 1'b0;
         r_ovf         <= 1'b0;
         r_mem_wr_en   <= 1'b0;
         r_mem_wr_idx  <= '0;
         r_mem_wr_tag  <= '0;
         r_mem_wr_data <= '0;
         r_fill_gnt    <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         if (w_pop) r_rd_ptr <= r_rd_ptr + ptr_t'(1);
         r_stall <= w_stall_nxt;
         if (w_drop) r_ovf <= 1'b1;
         // Clear on return precedes set on accept so a reused tag ends up holding the new load.
         if (w_ret_hit)  r_tv[mem2proc_tag] <= 1'b0;
         if (w_acc_load) r_tv[mem2proc_response] <= 1'b1;
         r_mem_wr_en <= w_ret_hit;
         if (w_ret_hit) begin
            r_mem_wr_tag  <= r_t_addr[mem2proc_tag][12:5];
            r_mem_wr_idx  <= r_t_addr[mem2proc_tag][4:0];
            r_mem_wr_data <= mem2proc_data;
            r_fill_gnt    <= r_t_gnt[mem2proc_tag];
         end
      end
   end

   assign req_stall    = r_stall;
   assign overflow_err = r_ovf;
   assign mem_wr_en    = r_mem_wr_en;
   assign mem_wr_idx   = r_mem_wr_idx;
   assign mem_wr_tag   = r_mem_wr_tag;
   assign mem_wr_data  = r_mem_wr_data;
   assign fill_gnt     = r_fill_gnt;

endmodule
